// File: rtl/instr_reg_decode_if.sv
// Bus between the multicycle control FSM/datapath and the instruction register decoder.
// The instret signal exists only when IRD_INSTRET_EN is defined.
interface instr_reg_decode_if;
    logic        load_ir;
    logic        flush;
    logic [31:0] instr_in;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ir_valid;
    logic        illegal;
`ifdef IRD_INSTRET_EN
    logic [31:0] instret;
`endif

    modport master (
        output load_ir, flush, instr_in,
        input  opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, ir_valid, illegal
`ifdef IRD_INSTRET_EN
        , input instret
`endif
    );

    modport slave (
        input  load_ir, flush, instr_in,
        output opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, ir_valid, illegal
`ifdef IRD_INSTRET_EN
        , output instret
`endif
    );
endinterface

// File: rtl/instr_reg_decode.sv
// Instruction register with RV32I field/immediate decode and sticky illegal-opcode flag.
// Optional loaded-instruction counter enabled by defining IRD_INSTRET_EN.
module instr_reg_decode #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic              CLK,
    input  logic              RST,
    instr_reg_decode_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd7
    } fmt_t;

    // Shared by the IR-side decode and the load-time legality check on instr_in.
    function automatic fmt_t fmt_of(input logic [6:0] op);
        fmt_t f;
        case (op)
            7'b0110011:                                     f = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: f = FMT_I;
            7'b0100011:                                     f = FMT_S;
            7'b1100011:                                     f = FMT_B;
            7'b0110111, 7'b0010111:                         f = FMT_U;
            7'b1101111:                                     f = FMT_J;
            default:                                        f = FMT_BAD;
        endcase
        return f;
    endfunction

    logic [XLEN-1:0] ir;
    state_t          state;
    state_t          state_next;
    logic            load_bad;
    fmt_t            ir_fmt;
    logic [XLEN-1:0] imm_dec;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir <= RESET_INSTR;
        end else if (bus.flush) begin
            ir <= RESET_INSTR;
        end else if (bus.load_ir) begin
            ir <= bus.instr_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign load_bad = (fmt_of(bus.instr_in[6:0]) == FMT_BAD);

    // A fault is sticky across later good loads; only flush or reset clears it.
    always_comb begin
        state_next   = state;
        bus.ir_valid = 1'b0;
        bus.illegal  = 1'b0;

        if (bus.flush) begin
            state_next = ST_EMPTY;
        end else if (bus.load_ir) begin
            if (load_bad || state == ST_FAULT) begin
                state_next = ST_FAULT;
            end else begin
                state_next = ST_VALID;
            end
        end

        case (state)
            ST_VALID: bus.ir_valid = 1'b1;
            ST_FAULT: begin
                bus.ir_valid = 1'b1;
                bus.illegal  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ir_fmt = fmt_of(ir[6:0]);

    always_comb begin
        imm_dec = '0;
        case (ir_fmt)
            FMT_I: imm_dec = {{20{ir[31]}}, ir[31:20]};
            FMT_S: imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U: imm_dec = {ir[31:12], 12'b0};
            FMT_J: imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_dec = '0;
        endcase
    end

    assign bus.opcode = ir[6:0];
    assign bus.rd     = ir[11:7];
    assign bus.funct3 = ir[14:12];
    assign bus.rs1    = ir[19:15];
    assign bus.rs2    = ir[24:20];
    assign bus.funct7 = ir[31:25];
    assign bus.imm    = imm_dec;
    assign bus.fmt    = ir_fmt;

`ifdef IRD_INSTRET_EN
    logic [31:0] instret_q;

    // Counts every accepted load, legal or not; a flush in the same cycle suppresses it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instret_q <= '0;
        end else if (bus.load_ir && !bus.flush) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.instret = instret_q;
`endif

endmodule
